// File: rtl/uart_word_ctrl.sv
// Packs UART bytes into a little-endian word and hands it off over valid/ready.
// Partial words are supervised by an inter-byte timeout; bytes that arrive while a word is held are dropped and flagged.
module uart_word_ctrl #(
    parameter int BYTES          = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    input  logic                         clear,
    output logic [8*BYTES-1:0]           word,
    output logic                         word_valid,
    input  logic                         word_ready,
    output logic [$clog2(BYTES+1)-1:0]   byte_count,
    output logic                         busy,
    output logic                         overrun,
    output logic                         timeout
);

    localparam int CW = $clog2(BYTES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(BYTES - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    state_t              state, state_n;
    logic [8*BYTES-1:0]  word_n;
    logic [CW-1:0]       count_n;
    logic [TW-1:0]       tcnt, tcnt_n;
    logic                overrun_n, timeout_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            word       <= '0;
            byte_count <= '0;
            tcnt       <= '0;
            overrun    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_n;
            word       <= word_n;
            byte_count <= count_n;
            tcnt       <= tcnt_n;
            overrun    <= overrun_n;
            timeout    <= timeout_n;
        end
    end

    always_comb begin
        state_n   = state;
        word_n    = word;
        count_n   = byte_count;
        tcnt_n    = tcnt;
        overrun_n = 1'b0;
        timeout_n = 1'b0;
        if (clear) begin
            state_n = IDLE;
            count_n = '0;
            tcnt_n  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rx_valid) begin
                        word_n[7:0] = rx_data;
                        count_n     = CW'(1);
                        tcnt_n      = '0;
                        state_n     = (BYTES == 1) ? DONE : RECV;
                    end
                end
                RECV: begin
                    if (rx_valid) begin
                        for (int i = 0; i < BYTES; i++) begin
                            if (byte_count == CW'(i)) word_n[8*i +: 8] = rx_data;
                        end
                        count_n = byte_count + CW'(1);
                        tcnt_n  = '0;
                        if (byte_count == LAST) state_n = DONE;
                    end else if (tcnt == TMAX) begin
                        state_n   = IDLE;
                        count_n   = '0;
                        tcnt_n    = '0;
                        timeout_n = 1'b1;
                    end else if (tcnt != '1) begin
                        tcnt_n = tcnt + TW'(1);
                    end
                end
                DONE: begin
                    if (word_ready) begin
                        state_n = IDLE;
                        count_n = '0;
                        // Back-to-back byte starts the next word in the hand-off cycle
                        if (rx_valid) begin
                            word_n[7:0] = rx_data;
                            count_n     = CW'(1);
                            tcnt_n      = '0;
                            state_n     = (BYTES == 1) ? DONE : RECV;
                        end
                    end else if (rx_valid) begin
                        overrun_n = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign word_valid = (state == DONE);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_word_ctrl.sv
// Bench for uart_word_ctrl: directed scenarios plus random traffic
// checked every cycle against a byte-list reference model.
module tb_uart_word_ctrl;

    localparam int BYTES = 4;
    localparam int TO    = 16;
    localparam int CW    = $clog2(BYTES + 1);

    logic                clk = 1'b0;
    logic                reset;
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic                clear;
    logic [8*BYTES-1:0]  word;
    logic                word_valid;
    logic                word_ready;
    logic [CW-1:0]       byte_count;
    logic                busy;
    logic                overrun;
    logic                timeout;

    int total = 0;
    int bad   = 0;

    // reference model: byte lanes, bytes gathered, word-held flag, idle gap
    logic [7:0] m_lane [BYTES];
    int         m_count;
    bit         m_held;
    int         m_gap;
    bit         m_ovr;
    bit         m_to;

    uart_word_ctrl #(.BYTES(BYTES), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .clear      (clear),
        .word       (word),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .byte_count (byte_count),
        .busy       (busy),
        .overrun    (overrun),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [8*BYTES-1:0] model_word();
        logic [8*BYTES-1:0] w;
        for (int i = 0; i < BYTES; i++) w[8*i +: 8] = m_lane[i];
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < BYTES; i++) m_lane[i] = 8'h00;
        m_count = 0;
        m_held  = 0;
        m_gap   = 0;
        m_ovr   = 0;
        m_to    = 0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] d,
                              input bit r, input bit c);
        m_ovr = 0;
        m_to  = 0;
        if (c) begin
            m_count = 0;
            m_held  = 0;
            m_gap   = 0;
        end else if (m_held) begin
            if (r) begin
                m_held  = 0;
                m_count = 0;
                if (v) begin
                    m_lane[0] = d;
                    m_count   = 1;
                    m_gap     = 0;
                    m_held    = (BYTES == 1);
                end
            end else if (v) begin
                m_ovr = 1;
            end
        end else if (v) begin
            m_lane[m_count] = d;
            m_count++;
            m_gap = 0;
            if (m_count == BYTES) m_held = 1;
        end else if (m_count > 0) begin
            if (m_gap == TO - 1) begin
                m_count = 0;
                m_gap   = 0;
                m_to    = 1;
            end else begin
                m_gap++;
            end
        end
    endtask

    task automatic compare_all(input string ph);
        check({ph, ".word"},       64'(word),       64'(model_word()));
        check({ph, ".word_valid"}, 64'(word_valid), 64'(m_held));
        check({ph, ".byte_count"}, 64'(byte_count), 64'(m_count));
        check({ph, ".busy"},       64'(busy),       64'(m_count > 0));
        check({ph, ".overrun"},    64'(overrun),    64'(m_ovr));
        check({ph, ".timeout"},    64'(timeout),    64'(m_to));
    endtask

    task automatic cyc(input string ph, input bit v, input logic [7:0] d,
                       input bit r, input bit c);
        rx_valid   = v;
        rx_data    = d;
        word_ready = r;
        clear      = c;
        @(posedge clk);
        model_step(v, d, r, c);
        #1;
        compare_all(ph);
    endtask

    task automatic idle(input string ph, input int n, input bit r);
        for (int i = 0; i < n; i++) cyc(ph, 1'b0, 8'h00, r, 1'b0);
    endtask

    initial begin
        reset      = 1'b1;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        clear      = 1'b0;
        word_ready = 1'b0;
        model_reset();
        #12;
        compare_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // 1: four bytes with 5-cycle gaps, consumer ready
        cyc("t1", 1, 8'h11, 1, 0); idle("t1", 5, 1);
        cyc("t1", 1, 8'h22, 1, 0); idle("t1", 5, 1);
        cyc("t1", 1, 8'h33, 1, 0); idle("t1", 5, 1);
        cyc("t1", 1, 8'h44, 1, 0);
        check("t1.word_exact", 64'(word), 64'h44332211);
        idle("t1", 2, 1);

        // 2: held word, extra byte overruns
        cyc("t2", 1, 8'h11, 0, 0);
        cyc("t2", 1, 8'h22, 0, 0);
        cyc("t2", 1, 8'h33, 0, 0);
        cyc("t2", 1, 8'h44, 0, 0);
        cyc("t2", 1, 8'h55, 0, 0);
        check("t2.overrun_pulse", 64'(overrun), 64'h1);
        check("t2.word_kept", 64'(word), 64'h44332211);
        idle("t2", 1, 0);
        idle("t2", 2, 1);

        // 3: timeout after two bytes, then a full word
        cyc("t3", 1, 8'hAA, 1, 0);
        cyc("t3", 1, 8'hBB, 1, 0);
        idle("t3", 15, 1);
        idle("t3", 1, 1);
        check("t3.timeout_pulse", 64'(timeout), 64'h1);
        idle("t3", 1, 1);
        for (int i = 1; i <= 4; i++) cyc("t3", 1, 8'(8'hA0 + i), 0, 0);
        check("t3.word_exact", 64'(word), 64'hA4A3A2A1);
        idle("t3", 1, 1);

        // 4: hand-off and new byte in the same cycle
        for (int i = 1; i <= 4; i++) cyc("t4", 1, 8'(i), 0, 0);
        cyc("t4", 1, 8'h99, 1, 0);
        check("t4.lane0", 64'(word[7:0]), 64'h99);
        check("t4.count1", 64'(byte_count), 64'h1);
        cyc("t4", 1, 8'h00, 0, 1);

        // 5: async reset mid-word
        cyc("t5", 1, 8'h07, 0, 0);
        cyc("t5", 1, 8'h08, 0, 0);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        compare_all("t5.async");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) cyc("t5", 1, 8'(i), 0, 0);
        check("t5.word_exact", 64'(word), 64'h04030201);
        idle("t5", 1, 1);

        // 6: clear with a byte at position 3
        cyc("t6", 1, 8'hE0, 0, 0);
        cyc("t6", 1, 8'hE1, 0, 0);
        cyc("t6", 1, 8'hE2, 0, 1);
        for (int i = 0; i < 4; i++) cyc("t6", 1, 8'(8'h10 + i), 0, 0);
        check("t6.word_exact", 64'(word), 64'h13121110);
        idle("t6", 1, 1);

        // random traffic with occasional long gaps and rare clears
        for (int n = 0; n < 400; n++) begin
            int mode;
            mode = int'($urandom_range(0, 9));
            if (mode == 0) begin
                idle("rnd", int'($urandom_range(10, 20)), 1'($urandom_range(0, 1)));
            end else begin
                cyc("rnd", ($urandom_range(0, 2) == 0), 8'($urandom),
                    ($urandom_range(0, 2) != 0), ($urandom_range(0, 40) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
